serial_subtractor: RTL and testbench

Parametrised multi-cycle subtractor: computes Diff = A − B − Bin over WIDTH-bit operands, processing DIGIT bits per clock, LSB digit first.
Borrow is carried between digits in a register.
Replaces the single-bit combinational subtractor where area matters more than latency, and adds a start/done handshake, a borrow-out and a signed-overflow flag.
Sits between operand registers and the accumulator datapath.

---
 rtl/sub_pkg.sv | 16 +
 rtl/sub_digit.sv | 27 ++
 rtl/serial_subtractor.sv | 149 ++++++++++++++
 tb/tb_serial_subtractor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package sub_pkg;

  // Controller states: waiting, shifting digits through, presenting the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the digit counter: enough to count 0..n-1 and never below one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit ripple-borrow subtract slice: d = a - b - bin.
// bmsb is the borrow entering the slice's top bit; it feeds the signed-overflow flag.
module sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout,
  output logic             bmsb
);

  // bc[i] is the borrow into bit i; bc[DIGIT] leaves the slice.
  logic [DIGIT:0] bc;

  assign bc[0] = bin;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
    assign d[gi]      = a[gi] ^ b[gi] ^ bc[gi];
    assign bc[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & bc[gi]);
  end

  assign bout = bc[DIGIT];
  assign bmsb = bc[DIGIT-1];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: Diff = A - B - Bin, DIGIT bits per clock, LSB digit first.
// One result every WIDTH/DIGIT + 1 cycles, with a start/done handshake and
// registered borrow-out and signed-overflow flags.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  // Reject parameter sets the digit datapath cannot cover exactly.
  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_subtractor: DIGIT must divide WIDTH");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("serial_subtractor: WIDTH must be at least 2");
  end

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              borrow_q, borrow_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DIGIT-1:0]  dig_d;
  logic              dig_bout;
  logic              dig_bmsb;
  logic [WIDTH-1:0]  res_shift;

  // The single slice always works on the low digit of the operand shift registers.
  sub_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .bin  (borrow_q),
    .d    (dig_d),
    .bout (dig_bout),
    .bmsb (dig_bmsb)
  );

  // New digit enters the result register from the MSB side, so after N
  // cycles the first (LSB) digit has reached bit 0.
  if (DIGIT == WIDTH) begin : g_res_full
    assign res_shift = dig_d;
  end else begin : g_res_shift
    assign res_shift = {dig_d, res_q[WIDTH-1:DIGIT]};
  end

  // Next-state, datapath and output-register updates.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          count_d  = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        res_d    = res_shift;
        borrow_d = dig_bout;
        count_d  = count_q + 1'b1;
        if (count_q == CW'(N - 1)) begin
          // Last digit: its internal top-bit borrow is the borrow into the word MSB.
          state_d = DONE;
          diff_d  = res_shift;
          bout_d  = dig_bout;
          ovf_d   = dig_bmsb ^ dig_bout;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: four instances (DIGIT = 1, 2, 4, 8) at WIDTH = 8,
// directed cases plus a random sweep against an integer-arithmetic reference.
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int NI = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   a_r, b_r;
  logic           bin_r;
  logic           start_r [NI];
  logic           busy_w  [NI];
  logic           done_w  [NI];
  logic [W-1:0]   diff_w  [NI];
  logic           bout_w  [NI];
  logic           ovf_w   [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_r[0]), .A(a_r), .B(b_r), .Bin(bin_r),
    .busy(busy_w[0]), .done(done_w[0]), .Diff(diff_w[0]), .Bout(bout_w[0]), .Ovf(ovf_w[0]));
  serial_subtractor #(.WIDTH(W), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start_r[1]), .A(a_r), .B(b_r), .Bin(bin_r),
    .busy(busy_w[1]), .done(done_w[1]), .Diff(diff_w[1]), .Bout(bout_w[1]), .Ovf(ovf_w[1]));
  serial_subtractor #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start_r[2]), .A(a_r), .B(b_r), .Bin(bin_r),
    .busy(busy_w[2]), .done(done_w[2]), .Diff(diff_w[2]), .Bout(bout_w[2]), .Ovf(ovf_w[2]));
  serial_subtractor #(.WIDTH(W), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start_r[3]), .A(a_r), .B(b_r), .Bin(bin_r),
    .busy(busy_w[3]), .done(done_w[3]), .Diff(diff_w[3]), .Bout(bout_w[3]), .Ovf(ovf_w[3]));

  // Instance k processes 2**k bits per cycle.
  function automatic int cycles_of(input int k);
    return W / (1 << k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, bout, diff}.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
    int u;
    int s;
    logic [W-1:0] d;
    logic bo;
    logic ov;
    u  = int'(a) - int'(b) - int'(bin);
    s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = W'(u);
    bo = (u < 0);
    ov = (s > ((1 << (W - 1)) - 1)) || (s < -(1 << (W - 1)));
    return {ov, bo, d};
  endfunction

  task automatic launch(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin);
    a_r = a;
    b_r = b;
    bin_r = bin;
    start_r[k] = 1'b1;
    $display("launch dut%0d A=0x%02h B=0x%02h Bin=%0d", k, a, b, bin);
  endtask

  // Called in the launch cycle (cycle 0); returns in the done cycle (cycle N+1).
  task automatic finish_op(input int k, input logic [W-1:0] ed, input logic eb,
                           input logic eo, input bit poke, input string tag);
    int n;
    n = cycles_of(k);
    step();
    start_r[k] = 1'b0;
    a_r   = W'($urandom);
    b_r   = W'($urandom);
    bin_r = 1'($urandom);
    for (int c = 1; c <= n; c++) begin
      chk({tag, " busy"}, 32'(busy_w[k]), 32'(1));
      chk({tag, " done_early"}, 32'(done_w[k]), 32'(0));
      if (poke && c == 3) begin
        start_r[k] = 1'b1;
        a_r = ~a_r;
      end else begin
        start_r[k] = 1'b0;
      end
      step();
    end
    start_r[k] = 1'b0;
    chk({tag, " busy_done"}, 32'(busy_w[k]), 32'(0));
    chk({tag, " done"}, 32'(done_w[k]), 32'(1));
    chk({tag, " diff"}, 32'(diff_w[k]), 32'(ed));
    chk({tag, " bout"}, 32'(bout_w[k]), 32'(eb));
    chk({tag, " ovf"}, 32'(ovf_w[k]), 32'(eo));
    $display("result dut%0d %s Diff=0x%02h Bout=%0d Ovf=%0d", k, tag, diff_w[k], bout_w[k], ovf_w[k]);
  endtask

  // One cycle after done: pulse gone, result held.
  task automatic idle_after(input int k, input logic [W-1:0] ed, input logic eb,
                            input logic eo, input string tag);
    step();
    chk({tag, " done_pulse"}, 32'(done_w[k]), 32'(0));
    chk({tag, " busy_idle"}, 32'(busy_w[k]), 32'(0));
    chk({tag, " hold_diff"}, 32'(diff_w[k]), 32'(ed));
    chk({tag, " hold_bout"}, 32'(bout_w[k]), 32'(eb));
    chk({tag, " hold_ovf"}, 32'(ovf_w[k]), 32'(eo));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t dir_tab [5] = '{
    '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0},
    '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0},
    '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1},
    '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0},
    '{8'h0F, 8'h0F, 1'b1, 8'hFF, 1'b1, 1'b0}
  };

  initial begin
    logic [W+1:0] r;
    logic [W-1:0] ra, rb;
    logic         rbin;

    rst = 1'b1;
    a_r = '0;
    b_r = '0;
    bin_r = 1'b0;
    for (int k = 0; k < NI; k++) start_r[k] = 1'b0;

    // Reset state on every instance.
    repeat (3) step();
    for (int k = 0; k < NI; k++) begin
      chk("reset busy", 32'(busy_w[k]), 32'(0));
      chk("reset done", 32'(done_w[k]), 32'(0));
      chk("reset diff", 32'(diff_w[k]), 32'(0));
      chk("reset bout", 32'(bout_w[k]), 32'(0));
      chk("reset ovf", 32'(ovf_w[k]), 32'(0));
    end
    rst = 1'b0;
    step();

    // Directed vectors, DIGIT=1.
    for (int i = 0; i < 5; i++) begin
      launch(0, dir_tab[i].a, dir_tab[i].b, dir_tab[i].bin);
      finish_op(0, dir_tab[i].d, dir_tab[i].bo, dir_tab[i].ov, 1'b0, "dir");
      idle_after(0, dir_tab[i].d, dir_tab[i].bo, dir_tab[i].ov, "dir");
    end

    // start in RUN with other operands is ignored.
    launch(0, 8'h33, 8'h11, 1'b0);
    finish_op(0, 8'h22, 1'b0, 1'b0, 1'b1, "poke");
    idle_after(0, 8'h22, 1'b0, 1'b0, "poke");

    // Back-to-back: second start in the done cycle, second done in cycle 18.
    launch(0, 8'h5A, 8'h3C, 1'b0);
    finish_op(0, 8'h1E, 1'b0, 1'b0, 1'b0, "b2b1");
    launch(0, 8'h00, 8'h01, 1'b0);
    finish_op(0, 8'hFF, 1'b1, 1'b0, 1'b0, "b2b2");
    idle_after(0, 8'hFF, 1'b1, 1'b0, "b2b2");

    // Reset in cycle 4 of a run: everything cleared, no done pulse.
    launch(0, 8'h5A, 8'h3C, 1'b0);
    step();
    start_r[0] = 1'b0;
    chk("rst_run busy1", 32'(busy_w[0]), 32'(1));
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_run busy", 32'(busy_w[0]), 32'(0));
    chk("rst_run done", 32'(done_w[0]), 32'(0));
    chk("rst_run diff", 32'(diff_w[0]), 32'(0));
    chk("rst_run bout", 32'(bout_w[0]), 32'(0));
    chk("rst_run ovf", 32'(ovf_w[0]), 32'(0));
    for (int c = 0; c < 10; c++) begin
      step();
      chk("rst_run no_done", 32'(done_w[0]), 32'(0));
    end

    // Reset and start together: start dropped.
    rst = 1'b1;
    launch(0, 8'h44, 8'h22, 1'b0);
    step();
    rst = 1'b0;
    start_r[0] = 1'b0;
    chk("rst_start busy", 32'(busy_w[0]), 32'(0));
    step();
    chk("rst_start busy2", 32'(busy_w[0]), 32'(0));
    chk("rst_start done", 32'(done_w[0]), 32'(0));

    // DIGIT=4: done in cycle 3.
    launch(2, 8'h7F, 8'h80, 1'b0);
    finish_op(2, 8'hFF, 1'b1, 1'b1, 1'b0, "d4");
    idle_after(2, 8'hFF, 1'b1, 1'b1, "d4");

    // Random sweep on all digit sizes, mixing back-to-back and idle gaps.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 25; i++) begin
        ra   = W'($urandom);
        rb   = W'($urandom);
        rbin = 1'($urandom);
        if (i == 0) begin
          ra = 8'hFF;
          rb = 8'hFF;
          rbin = 1'b1;
        end
        r = ref_sub(ra, rb, rbin);
        launch(k, ra, rb, rbin);
        finish_op(k, r[W-1:0], r[W], r[W+1], 1'b0, "rnd");
        if ($urandom_range(0, 1) == 1 || i == 24) begin
          idle_after(k, r[W-1:0], r[W], r[W+1], "rnd");
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
